spi_slave_regfile: RTL and testbench

Register bank sitting directly downstream of `spi_slave`. It consumes the decoded address, received data and end-of-frame pulse, commits SPI writes into a parameterised 16-bit register array, and returns read data on `txdata` in time for the slave to shift it out on MISO. A second port gives local fabric logic read/write access to the same array. It also keeps frame and error counters for bring-up.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/cdc_sync2.sv | 23 ++
 rtl/spi_slave_regfile.sv | 192 +++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank:
// R/W encoding, reserved indices and controller states.
package spi_pkg;

    localparam logic SPI_RD = 1'b1;

    localparam int IDX_ID   = 0;
    localparam int IDX_FCNT = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COMMIT
    } state_t;

    // R/W flag sits in the MSB of the address byte
    function automatic int rw_pos(input int aw);
        return aw - 1;
    endfunction

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchroniser for a level signal that idles high
// (chip select). Both flops come out of reset at 1.
module cdc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the async level through two flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slave_regfile.sv
// Register bank behind spi_slave: SPI frame commit, local
// fabric port, read-back mux and bring-up counters.
module spi_slave_regfile
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = 16'hA55A,
    parameter logic [DATA_WIDTH-1:0] BAD_READ = 16'hDEAD,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_cs,
    input  logic                  addr_valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rxdata,
    input  logic                  spi_over,
    output logic [DATA_WIDTH-1:0] txdata,
    input  logic                  loc_we,
    input  logic [IW-1:0]         loc_addr,
    input  logic [DATA_WIDTH-1:0] loc_wdata,
    output logic [DATA_WIDTH-1:0] loc_rdata,
    output logic                  loc_wr_drop,
    output logic                  upd_strobe,
    output logic [IW-1:0]         upd_index,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            err_cnt
);

    localparam int RW = rw_pos(ADDR_WIDTH);
    localparam int XW = ADDR_WIDTH - 1;

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    logic [XW-1:0]         sp_idx;
    logic                  sp_rw;
    logic [DATA_WIDTH-1:0] sp_data;

    logic cs_sync, cs_q, cs_rise;

    logic [XW-1:0]         av_idx;
    logic                  av_rd;
    logic                  av_in_range;
    logic [DATA_WIDTH-1:0] av_val;
    logic [DATA_WIDTH-1:0] loc_val;
    logic                  wr_ok;

    logic       start, cap, fcnt_inc, spi_we, err_a, err_b;
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    cdc_sync2 u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_cs),
        .q     (cs_sync)
    );

    // remember the synchronised level to find its rising edge
    always_ff @(posedge clk) begin
        if (!rst_n) cs_q <= 1'b1;
        else        cs_q <= cs_sync;
    end

    assign cs_rise = cs_sync & ~cs_q;

    assign av_idx      = addr[XW-1:0];
    assign av_rd       = (addr[RW] == SPI_RD);
    assign av_in_range = (32'(av_idx) < DEPTH);

    assign wr_ok = (sp_rw != SPI_RD)
                 && (32'(sp_idx) < DEPTH)
                 && (32'(sp_idx) > IDX_FCNT);

    // read-back value for the address just received
    always_comb begin
        av_val = BAD_READ;
        if (!av_in_range)
            av_val = BAD_READ;
        else if (32'(av_idx) == IDX_ID)
            av_val = ID_VALUE;
        else if (32'(av_idx) == IDX_FCNT)
            av_val = DATA_WIDTH'(frame_cnt);
        else
            av_val = regs[av_idx[IW-1:0]];
    end

    // read-back value for the local port
    always_comb begin
        loc_val = regs[loc_addr];
        if (32'(loc_addr) == IDX_ID)
            loc_val = ID_VALUE;
        else if (32'(loc_addr) == IDX_FCNT)
            loc_val = DATA_WIDTH'(frame_cnt);
    end

    // controller state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next state and per-cycle action strobes
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        cap      = 1'b0;
        fcnt_inc = 1'b0;
        spi_we   = 1'b0;
        err_a    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (addr_valid) begin
                    start    = 1'b1;
                    state_nx = S_ARMED;
                end else if (spi_over) begin
                    err_a = 1'b1;
                end
            end
            S_ARMED: begin
                if (spi_over) begin
                    cap      = 1'b1;
                    state_nx = S_COMMIT;
                end else if (addr_valid) begin
                    start = 1'b1;
                    err_a = 1'b1;
                end else if (cs_rise) begin
                    err_a    = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_COMMIT: begin
                fcnt_inc = 1'b1;
                state_nx = S_IDLE;
                if (wr_ok)
                    spi_we = 1'b1;
                else if (sp_rw != SPI_RD)
                    err_a = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign err_b   = start & av_rd & ~av_in_range;
    assign err_inc = {1'b0, err_a} + {1'b0, err_b};
    assign err_sum = {1'b0, err_cnt} + {7'b0, err_inc};

    assign upd_strobe  = spi_we;
    assign upd_index   = sp_idx[IW-1:0];
    assign loc_wr_drop = loc_we & spi_we;

    // frame latches, tx data, counters and local read register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_idx    <= '0;
            sp_rw     <= 1'b0;
            sp_data   <= '0;
            txdata    <= '0;
            loc_rdata <= '0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (start) begin
                sp_idx <= av_idx;
                sp_rw  <= av_rd;
                txdata <= av_rd ? av_val : '0;
            end
            if (cap)
                sp_data <= rxdata;
            frame_cnt <= frame_cnt + {15'b0, fcnt_inc};
            err_cnt   <= err_sum[8] ? 8'hFF : err_sum[7:0];
            loc_rdata <= loc_val;
        end
    end

    // register array; an SPI commit beats a local write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (spi_we) begin
            regs[sp_idx[IW-1:0]] <= sp_data;
        end else if (loc_we && 32'(loc_addr) > IDX_FCNT) begin
            regs[loc_addr] <= loc_wdata;
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: directed frames
// then random frames against a frame-level reference model.
module tb_spi_slave_regfile;

    localparam int DEPTH = 64;
    localparam logic [15:0] ID  = 16'hA55A;
    localparam logic [15:0] BAD = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        addr_valid = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] rxdata = '0;
    logic        spi_over = 1'b0;
    logic [15:0] txdata;
    logic        loc_we = 1'b0;
    logic [5:0]  loc_addr = '0;
    logic [15:0] loc_wdata = '0;
    logic [15:0] loc_rdata;
    logic        loc_wr_drop;
    logic        upd_strobe;
    logic [5:0]  upd_index;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    spi_slave_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_cs      (spi_cs),
        .addr_valid  (addr_valid),
        .addr        (addr),
        .rxdata      (rxdata),
        .spi_over    (spi_over),
        .txdata      (txdata),
        .loc_we      (loc_we),
        .loc_addr    (loc_addr),
        .loc_wdata   (loc_wdata),
        .loc_rdata   (loc_rdata),
        .loc_wr_drop (loc_wr_drop),
        .upd_strobe  (upd_strobe),
        .upd_index   (upd_index),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [DEPTH];
    int fcnt;
    int errc;
    int ncmp;
    int nfail;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_rd(input int idx);
        if (idx >= DEPTH) return BAD;
        if (idx == 0) return ID;
        if (idx == 1) return 16'(fcnt);
        return mem[idx];
    endfunction

    task automatic err_bump();
        if (errc < 255) errc++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        fcnt = 0;
        errc = 0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(fcnt));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(errc));
    endtask

    // one SPI frame; optional cs abort or a colliding local write
    task automatic spi_frame(input logic [7:0] a,
                             input logic [15:0] d,
                             input bit abort,
                             input bit collide,
                             input logic [15:0] lw);
        int idx;
        int lidx;
        bit rd;
        bit ok_wr;
        logic [15:0] exp_tx;
        idx = int'(a[6:0]);
        rd = a[7];
        lidx = idx % DEPTH;
        spi_cs = 1'b0;
        tick();
        tick();
        addr = a;
        addr_valid = 1'b1;
        exp_tx = rd ? model_rd(idx) : 16'h0;
        if (rd && idx >= DEPTH) err_bump();
        tick();
        addr_valid = 1'b0;
        #1 chk("txdata", 32'(txdata), 32'(exp_tx));
        repeat (3) tick();
        if (abort) begin
            spi_cs = 1'b1;
            repeat (4) tick();
            err_bump();
            #1 chk("abort.upd_strobe", 32'(upd_strobe), 0);
        end else begin
            rxdata = d;
            spi_over = 1'b1;
            tick();
            spi_over = 1'b0;
            ok_wr = !rd && idx >= 2 && idx < DEPTH;
            if (collide) begin
                loc_we = 1'b1;
                loc_addr = 6'(lidx);
                loc_wdata = lw;
            end
            #1 chk("upd_strobe", 32'(upd_strobe), 32'(ok_wr));
            if (ok_wr)
                chk("upd_index", 32'(upd_index), 32'(idx));
            if (collide)
                chk("loc_wr_drop", 32'(loc_wr_drop), 32'(ok_wr));
            tick();
            loc_we = 1'b0;
            fcnt = (fcnt + 1) % 65536;
            if (ok_wr) mem[idx] = d;
            else if (!rd) err_bump();
            if (collide && !ok_wr && lidx >= 2) mem[lidx] = lw;
            spi_cs = 1'b1;
            tick();
            tick();
        end
        #1 check_counts("frame");
    endtask

    task automatic loc_write(input int idx, input logic [15:0] d);
        logic [15:0] old;
        old = model_rd(idx);
        loc_we = 1'b1;
        loc_addr = 6'(idx);
        loc_wdata = d;
        tick();
        loc_we = 1'b0;
        #1 chk("read_old", 32'(loc_rdata), 32'(old));
        if (idx >= 2) mem[idx] = d;
    endtask

    task automatic loc_check(input int idx);
        loc_addr = 6'(idx);
        tick();
        #1 chk("loc_rdata", 32'(loc_rdata), 32'(model_rd(idx)));
    endtask

    task automatic idle_over();
        rxdata = 16'(($urandom));
        spi_over = 1'b1;
        tick();
        spi_over = 1'b0;
        err_bump();
    endtask

    initial begin
        ncmp = 0;
        nfail = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst.txdata", 32'(txdata), 0);
        chk("rst.loc_rdata", 32'(loc_rdata), 0);
        chk("rst.upd_strobe", 32'(upd_strobe), 0);
        check_counts("rst");

        // write 0x1234 to index 60, read it back
        spi_frame(8'h3C, 16'h1234, 0, 0, 16'h0);
        spi_frame(8'hBC, 16'h0, 0, 0, 16'h0);
        chk("fc_after2", 32'(frame_cnt), 2);
        // out-of-range read
        spi_frame(8'hF8, 16'h0, 0, 0, 16'h0);
        // ID read, then dropped write to index 0
        spi_frame(8'h80, 16'h0, 0, 0, 16'h0);
        spi_frame(8'h00, 16'h4321, 0, 0, 16'h0);
        loc_check(0);
        // frame counter readable at index 1
        spi_frame(8'h81, 16'h0, 0, 0, 16'h0);
        // cs abort on a write to index 5
        loc_write(5, 16'h5555);
        spi_frame(8'h05, 16'h7777, 1, 0, 16'h0);
        loc_check(5);
        spi_frame(8'h85, 16'h0, 0, 0, 16'h0);
        // collision: SPI wins
        spi_frame(8'h3C, 16'h4444, 0, 1, 16'h0BAD);
        loc_check(60);
        // local writes, including ignored reserved index
        loc_write(1, 16'hBEEF);
        loc_check(1);
        loc_write(63, 16'hC0DE);
        loc_check(63);
        spi_frame(8'hBF, 16'h0, 0, 0, 16'h0);
        // spi_over in IDLE
        idle_over();
        #1 check_counts("idle_over");

        // random frames and local traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] a;
            a[7] = 1'($urandom_range(0, 1));
            a[6:0] = 7'($urandom_range(0, 71));
            spi_frame(a, 16'($urandom),
                      ($urandom_range(0, 7) == 0), 0, 16'h0);
            if ($urandom_range(0, 2) == 0)
                loc_write($urandom_range(0, DEPTH - 1),
                          16'($urandom));
            loc_check($urandom_range(0, DEPTH - 1));
        end

        // err_cnt saturation
        repeat (260) idle_over();
        #1 check_counts("sat");
        chk("sat.err", 32'(err_cnt), 255);

        // reset in the middle of a frame
        spi_cs = 1'b0;
        tick();
        addr = 8'h0A;
        addr_valid = 1'b1;
        tick();
        addr_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        model_reset();
        chk("mrst.txdata", 32'(txdata), 0);
        chk("mrst.loc_rdata", 32'(loc_rdata), 0);
        chk("mrst.upd_strobe", 32'(upd_strobe), 0);
        chk("mrst.loc_wr_drop", 32'(loc_wr_drop), 0);
        check_counts("mrst");
        rst_n = 1'b1;
        spi_cs = 1'b1;
        tick();
        idle_over();
        #1 check_counts("post_rst");
        loc_check(60);
        loc_check(10);
        spi_frame(8'h0A, 16'h2468, 0, 0, 16'h0);
        loc_check(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
